// File: rtl/imm_gen_q.sv
// ---------------------------------------------------------------------------
// imm_gen_q
// Decode-stage immediate generator with an in-order result queue.
//
// Every RV32I immediate format (I, S, B, U, J) is decoded combinationally at
// the input, sign-extended to XLEN bits and tagged with its format. The
// decoded result (not the raw instruction) is pushed into a DEPTH-entry FIFO.
// This lets decode run ahead of a stalled execute stage.
//
// Parameters
//   XLEN   immediate width, 32 or 64
//   DEPTH  queue entries, power of two, >= 2
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     instr/imm_en presented
//   in_ready     queue can accept (registered !full)
//   instr        32-bit instruction word
//   imm_en       0 forces the entry to imm=0, fmt=0
//   out_valid    queue head valid
//   out_ready    consumer takes the head
//   imm_ext      head immediate, XLEN bits
//   imm_fmt      head format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//   count        queue occupancy
//   illegal      head opcode unrecognised   (IMMGEN_ILLEGAL_EN only)
//   illegal_cnt  saturating count of illegal pushes (IMMGEN_ILLEGAL_EN only)
//
// Optional feature macro: IMMGEN_ILLEGAL_EN
// ---------------------------------------------------------------------------
module imm_gen_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic                     imm_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          imm_ext,
    output logic [2:0]               imm_fmt,
    output logic [$clog2(DEPTH):0]   count
`ifdef IMMGEN_ILLEGAL_EN
    ,
    output logic                     illegal,
    output logic [15:0]              illegal_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_immDec;
    logic [2:0]      w_fmtDec;
    logic            w_unknown;
    logic            w_illDec;

    logic [XLEN-1:0] r_immMem [DEPTH];
    logic [2:0]      r_fmtMem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    // Decode the 32-bit form of the immediate first; every format carries its
    // sign in instr[31], so widening to XLEN just replicates bit 31.
    always_comb begin
        w_imm32   = '0;
        w_fmtDec  = FMT_NONE;
        w_unknown = 1'b0;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_imm32  = {{20{instr[31]}}, instr[31:20]};
                w_fmtDec = FMT_I;
            end
            7'b0100011: begin
                w_imm32  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                w_fmtDec = FMT_S;
            end
            7'b1100011: begin
                w_imm32  = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
                w_fmtDec = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                w_imm32  = {instr[31:12], 12'b0};
                w_fmtDec = FMT_U;
            end
            7'b1101111: begin
                w_imm32  = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
                w_fmtDec = FMT_J;
            end
            default: begin
                w_unknown = 1'b1;
            end
        endcase

        w_immDec       = {XLEN{w_imm32[31]}};
        w_immDec[31:0] = w_imm32;
        w_illDec       = w_unknown;

        if (!imm_en) begin
            w_immDec = '0;
            w_fmtDec = FMT_NONE;
            w_illDec = 1'b0;
        end
    end

    // Full/empty come straight from the registered count, so in_ready has
    // no combinational dependence on out_ready.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_ready && !w_empty;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;

    // Queue storage holds decoded results only; it needs no reset because
    // the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_immMem[r_wptr] <= w_immDec;
            r_fmtMem[r_wptr] <= w_fmtDec;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks push/pop imbalance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign imm_ext = w_empty ? '0 : r_immMem[r_rptr];
    assign imm_fmt = w_empty ? FMT_NONE : r_fmtMem[r_rptr];

`ifdef IMMGEN_ILLEGAL_EN
    logic            r_illMem [DEPTH];
    logic [15:0]     r_illCnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_illMem[r_wptr] <= w_illDec;
        end
    end

    // Saturating count of illegal entries accepted into the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illCnt <= '0;
        end else if (w_push && w_illDec && (r_illCnt != 16'hFFFF)) begin
            r_illCnt <= r_illCnt + 16'd1;
        end
    end

    assign illegal     = w_empty ? 1'b0 : r_illMem[r_rptr];
    assign illegal_cnt = r_illCnt;
`else
    logic w_illUnused;
    assign w_illUnused = w_illDec;
`endif

endmodule

// File: doc/imm_gen_q.md
# imm_gen_q

Parametrised, pipelined immediate generator for the decode stage. Decodes and sign-extends the immediate of every RV32I format (I, S, B, U, J) to XLEN bits and tags each result with its format. Results go into a small in-order queue with valid/ready handshakes on both sides, so decode can run ahead of a stalled execute stage. Sits between instruction fetch/decode and the ALU/branch operand mux.

## Interface
- `XLEN`, 32, immediate output width; legal values are 32 or 64.
- `DEPTH`, 4, queue entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `instr`/`imm_en` are presented.
- `in_ready`  out  1  queue can accept; equals `!full`.
- `instr`  in  32  instruction word.
- `imm_en`  in  1  when 0, the entry is written with imm=0 and fmt=0.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  consumer takes the head.
- `imm_ext`  out  XLEN  head immediate.
- `imm_fmt`  out  3  head format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `illegal`  out  1  head opcode unrecognised (only with `IMMGEN_ILLEGAL_EN`).
- `illegal_cnt`  out  16  saturating count of illegal entries pushed (only with `IMMGEN_ILLEGAL_EN`).

## Operation
- Opcode is `instr[6:0]`. I: 0010011, 0000011, 1100111. S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111. Any other opcode gives fmt 0 and imm 0.
- I: sext(instr[31:20]). S: sext({instr[31:25],instr[11:7]}). B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}). U: sext({instr[31:12],12'b0}). J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- Sign extension always replicates `instr[31]` up to bit XLEN-1, including U-type when XLEN=64.
- Shift-immediate I-type instructions get the raw 12-bit field, with no special shamt handling.
- Decode happens combinationally at the input. The decoded imm and fmt are stored in the queue, not the raw instruction.
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`. Order is strictly FIFO.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Simultaneous push and pop while not full: both happen and `count` is unchanged.
- Full: `in_ready`=0 even if a pop happens the same cycle, so there is no combinational path from `out_ready` to `in_ready`.
- Empty: `out_valid`=0, and `imm_ext`, `imm_fmt` and `illegal` are all driven to 0.
- Pop while empty, or push while full, is ignored with no state change.

## Timing
- Latency is 1 cycle. An entry pushed at edge N is visible on the outputs with `out_valid`=1 after edge N; there is no bypass.
- Outputs are taken from registered queue storage at the head pointer, with no logic depth after the register read.
- Reset (`rst_n`=0) asynchronously clears pointers, `count` and `illegal_cnt`. `out_valid`, `imm_ext`, `imm_fmt` and `illegal` go to 0 immediately, and `in_ready`=1.
- Pushes are ignored while `rst_n`=0.
- Reset in the middle of operation discards all queued entries. The first push after `rst_n` rises appears one cycle later, as usual.
- Throughput is one push and one pop per cycle sustained.

## Configuration
- `IMMGEN_ILLEGAL_EN` defined:
  - Each entry stores an illegal bit, set when the opcode is unrecognised and `imm_en`=1.
  - `illegal` reflects the head entry's bit.
  - `illegal_cnt` increments on each push of an illegal entry and saturates at 0xFFFF.
- Not defined:
  - The `illegal` and `illegal_cnt` ports are absent.
  - No extra storage is built.
  - Unrecognised opcodes still produce fmt 0 and imm 0.

## Test plan
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) -> next cycle `out_valid`=1, `imm_ext`=0xFFFFFFFF, `imm_fmt`=1.
- Push 0xFE101EE3 (bne x0,x1,-4), then 0x123452B7 (lui x5,0x12345), with `out_ready`=1:
  - first result 0xFFFFFFFC fmt 3;
  - second result 0x12345000 fmt 4, in order.
- XLEN=64, push 0x80000537 (lui) -> `imm_ext`=0xFFFFFFFF80000000, fmt 4. Push with `imm_en`=0 -> imm 0, fmt 0.
- DEPTH=4, `out_ready`=0, push 5 words:
  - `in_ready` drops after the 4th push and `count`=4;
  - the 5th word is held at the input;
  - raising `out_ready` drains all entries in order, and the 5th is accepted the cycle after the first pop.
- Push 2 entries, then pull `rst_n` low mid-cycle -> `out_valid` and `count` are 0 immediately; after release the queue is empty and accepts new entries.
- With `IMMGEN_ILLEGAL_EN`:
  - push 0x00B50533 (R-type add) -> `illegal`=1, imm 0, `illegal_cnt`=1;
  - push 0xFFF00093 -> `illegal`=0 and the count is unchanged.
